// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: prefetch queue sizing, reset vector and the
// queue entry layout, which matches the IF/ID register (pc4 in [63:32], ins in [31:0]).
package cpu_pkg;

    localparam int unsigned IFQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned INSTR_W   = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] pc4;
        logic [INSTR_W-1:0] ins;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Prefetch queue entry array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the queue control masks stale entries.
module ifq_storage
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  ifq_entry_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output ifq_entry_t    rdata_o
);

    ifq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch prefetch queue: fetches from a combinational instruction memory
// into a small FIFO feeding the IF/ID register, with flush-and-refetch on redirect.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = cpu_pkg::IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            im_addr,
    input  logic [31:0]            im_data,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_addr,
    output logic                   out_valid,
    output logic [31:0]            out_pc4,
    output logic [31:0]            out_ins,
    output logic [$clog2(DEPTH):0] occupancy
);
    import cpu_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic       enq;
    logic       deq;
    logic [31:0] fetch_pc4;
    ifq_entry_t wr_entry;
    ifq_entry_t head;

    assign fetch_pc4 = fetch_pc_q + 32'd4;
    assign out_valid = (count_q != '0);
    // A dequeue frees a slot in the same cycle, so a full queue can still accept.
    assign deq       = out_valid && !stall && !redirect;
    assign enq       = !redirect && ((count_q < Full) || deq);

    assign wr_entry.pc4 = fetch_pc4;
    assign wr_entry.ins = im_data;

    ifq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk_i   (clk),
        .we_i    (enq),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_addr[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc4;
                wr_ptr_d   = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign im_addr   = fetch_pc_q;
    assign occupancy = count_q;
    assign out_pc4   = out_valid ? head.pc4 : 32'd0;
    assign out_ins   = out_valid ? head.ins : 32'd0;

endmodule
